// File: rtl/dmem_arbiter_if.sv
// Data-memory arbiter bus bundle.
// Two requester ports, a lock hint and the memory side.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 10
`endif

interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = 32
);
  localparam int SW = DATA_WIDTH / 8;

  logic                  m0_req;
  logic                  m0_we;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic [SW-1:0]         m0_wstrb;
  logic                  m0_gnt;
  logic                  m0_rvalid;
  logic [DATA_WIDTH-1:0] m0_rdata;

  logic                  m1_req;
  logic                  m1_we;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic [SW-1:0]         m1_wstrb;
  logic                  m1_lock;
  logic                  m1_gnt;
  logic                  m1_rvalid;
  logic [DATA_WIDTH-1:0] m1_rdata;

  logic                  cpu_stall;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [SW-1:0]         mem_wstrb;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output m0_req, m0_we, m0_addr,
    output m0_wdata, m0_wstrb,
    output m1_req, m1_we, m1_addr,
    output m1_wdata, m1_wstrb, m1_lock,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  cpu_stall,
    input  mem_en, mem_we, mem_addr,
    input  mem_wdata, mem_wstrb
  );

  modport slave (
    input  m0_req, m0_we, m0_addr,
    input  m0_wdata, m0_wstrb,
    input  m1_req, m1_we, m1_addr,
    input  m1_wdata, m1_wstrb, m1_lock,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output cpu_stall,
    output mem_en, mem_we, mem_addr,
    output mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin data-memory arbiter, CPU vs host port.
// Same-cycle grant, bounded host lock, CPU stall on denial.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 10
`endif

module dmem_arbiter #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOCK   = 4
) (
  input logic          clk,
  input logic          reset,
  dmem_arbiter_if.slave bus
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int LW = $clog2(MAX_LOCK + 1);
  localparam logic [LW-1:0] LOCK_MAX =
    LW'(MAX_LOCK);

  logic          last_gnt;
  logic [LW-1:0] lock_cnt;
  logic [1:0]    rd_owner;

  logic locked;
  logic g0;
  logic g1;

  logic                  we_mux;
  logic [ADDR_WIDTH-1:0] addr_mux;
  logic [DATA_WIDTH-1:0] wdata_mux;
  logic [SW-1:0]         wstrb_mux;

  // Pick the winner: host lock first, else round-robin.
  always_comb begin
    locked = (lock_cnt != '0)
           && (lock_cnt < LOCK_MAX)
           && bus.m1_lock;
    g0 = bus.m0_req
       & (~bus.m1_req | (~locked & last_gnt));
    g1 = bus.m1_req
       & (~bus.m0_req | locked | ~last_gnt);
  end

  // Steer the winner's access onto the memory port.
  always_comb begin
    we_mux    = 1'b0;
    addr_mux  = '0;
    wdata_mux = '0;
    wstrb_mux = '0;
    unique case (1'b1)
      g0: begin
        we_mux    = bus.m0_we;
        addr_mux  = bus.m0_addr;
        wdata_mux = bus.m0_wdata;
        wstrb_mux = bus.m0_we ? bus.m0_wstrb : '0;
      end
      g1: begin
        we_mux    = bus.m1_we;
        addr_mux  = bus.m1_addr;
        wdata_mux = bus.m1_wdata;
        wstrb_mux = bus.m1_we ? bus.m1_wstrb : '0;
      end
      default: ;
    endcase
  end

  assign bus.m0_gnt    = g0;
  assign bus.m1_gnt    = g1;
  assign bus.cpu_stall = bus.m0_req & ~g0;
  assign bus.mem_en    = g0 | g1;
  assign bus.mem_we    = we_mux;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.mem_wstrb = wstrb_mux;
  assign bus.m0_rvalid = rd_owner[0];
  assign bus.m1_rvalid = rd_owner[1];
  assign bus.m0_rdata  = bus.mem_rdata;
  assign bus.m1_rdata  = bus.mem_rdata;

  // Track last winner, lock run length and read owner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt <= 1'b1;
      lock_cnt <= '0;
      rd_owner <= '0;
    end else begin
      if (g0 | g1)
        last_gnt <= g1;
      if (g1 & bus.m1_lock)
        lock_cnt <= (lock_cnt == LOCK_MAX)
                  ? LOCK_MAX
                  : lock_cnt + 1'b1;
      else
        lock_cnt <= '0;
      rd_owner <= {g1 & ~bus.m1_we,
                   g0 & ~bus.m0_we};
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed steps then random
// traffic against a rule-level reference model.
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int ML = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) bus ();

  dmem_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_LOCK(ML)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // memory array seen by the DUT
  logic [DW-1:0] tmem [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int i = 0; i < SW; i++)
          if (bus.mem_wstrb[i])
            tmem[bus.mem_addr][8*i +: 8] <=
              bus.mem_wdata[8*i +: 8];
      end else begin
        bus.mem_rdata <= tmem[bus.mem_addr];
      end
    end
  end

  // reference model state
  logic [DW-1:0] mmem [DEPTH];
  int  last_w;
  int  streak;
  bit  erv0;
  bit  erv1;
  logic [DW-1:0] erd;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    last_w = 1;
    streak = 0;
    erv0   = 1'b0;
    erv1   = 1'b0;
  endtask

  task automatic drive(
    input bit r0, input bit w0,
    input logic [AW-1:0] a0,
    input logic [DW-1:0] d0,
    input logic [SW-1:0] s0,
    input bit r1, input bit w1,
    input logic [AW-1:0] a1,
    input logic [DW-1:0] d1,
    input logic [SW-1:0] s1,
    input bit lk);
    bus.m0_req   = r0;
    bus.m0_we    = w0;
    bus.m0_addr  = a0;
    bus.m0_wdata = d0;
    bus.m0_wstrb = s0;
    bus.m1_req   = r1;
    bus.m1_we    = w1;
    bus.m1_addr  = a1;
    bus.m1_wdata = d1;
    bus.m1_wstrb = s1;
    bus.m1_lock  = lk;
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0);
  endtask

  // one clock: check at negedge, advance model at posedge
  task automatic cyc();
    int w;
    logic we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    @(negedge clk);
    w = -1;
    if (bus.m0_req && bus.m1_req) begin
      if (streak > 0 && streak < ML && bus.m1_lock)
        w = 1;
      else
        w = 1 - last_w;
    end else if (bus.m0_req) w = 0;
    else if (bus.m1_req) w = 1;
    we = 1'b0; a = '0; d = '0; s = '0;
    if (w == 0) begin
      we = bus.m0_we; a = bus.m0_addr;
      d = bus.m0_wdata; s = bus.m0_wstrb;
    end
    if (w == 1) begin
      we = bus.m1_we; a = bus.m1_addr;
      d = bus.m1_wdata; s = bus.m1_wstrb;
    end
    chk("m0_gnt", 64'(bus.m0_gnt), 64'(w == 0));
    chk("m1_gnt", 64'(bus.m1_gnt), 64'(w == 1));
    chk("cpu_stall", 64'(bus.cpu_stall),
        64'(bus.m0_req && w != 0));
    chk("mem_en", 64'(bus.mem_en), 64'(w >= 0));
    chk("mem_we", 64'(bus.mem_we), 64'(we));
    chk("mem_addr", 64'(bus.mem_addr), 64'(a));
    chk("mem_wdata", 64'(bus.mem_wdata), 64'(d));
    chk("mem_wstrb", 64'(bus.mem_wstrb),
        64'(we ? s : '0));
    chk("m0_rvalid", 64'(bus.m0_rvalid), 64'(erv0));
    chk("m1_rvalid", 64'(bus.m1_rvalid), 64'(erv1));
    if (erv0)
      chk("m0_rdata", 64'(bus.m0_rdata), 64'(erd));
    if (erv1)
      chk("m1_rdata", 64'(bus.m1_rdata), 64'(erd));
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      erv0 = (w == 0) && !we;
      erv1 = (w == 1) && !we;
      if (w >= 0 && !we) erd = mmem[a];
      if (w >= 0 && we)
        for (int i = 0; i < SW; i++)
          if (s[i]) mmem[a][8*i +: 8] = d[8*i +: 8];
      if (w >= 0) last_w = w;
      if (w == 1 && bus.m1_lock)
        streak = (streak < ML) ? streak + 1 : ML;
      else
        streak = 0;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      tmem[i] = DW'(i * 32'h0101_0101) ^ 32'h5A5A_0000;
      mmem[i] = tmem[i];
    end
    tmem[8'h10] = 32'hDEAD_BEEF;
    mmem[8'h10] = 32'hDEAD_BEEF;
    reset = 1'b1;
    model_reset();
    idle();
    cyc();
    // reads under reset: grant follows inputs, no rvalid
    drive(1, 0, 8'h01, '0, '0,
          1, 0, 8'h02, '0, '0, 0);
    cyc();
    idle();
    cyc();
    reset = 1'b0;

    // contention from reset: m0, m1, m0, m1
    drive(1, 0, 8'h01, '0, '0,
          1, 0, 8'h02, '0, '0, 0);
    repeat (4) cyc();
    idle();
    cyc();

    // lone CPU read of 0x10
    drive(1, 0, 8'h10, '0, '0,
          0, 0, '0, '0, '0, 0);
    cyc();
    idle();
    cyc();

    // locked host burst against waiting CPU
    drive(1, 0, 8'h05, '0, '0,
          1, 0, 8'h06, '0, '0, 1);
    repeat (7) cyc();
    idle();
    cyc();

    // locked host alone: holds grant, count saturates
    drive(0, 0, '0, '0, '0,
          1, 0, 8'h07, '0, '0, 1);
    repeat (6) cyc();
    drive(1, 0, 8'h05, '0, '0,
          1, 0, 8'h06, '0, '0, 1);
    repeat (2) cyc();
    idle();
    cyc();

    // host partial write, then CPU reads it back
    drive(0, 0, '0, '0, '0,
          1, 1, 8'h03, 32'hCAFE_0000, 4'h3, 0);
    cyc();
    idle();
    cyc();
    drive(1, 0, 8'h03, '0, '0,
          0, 0, '0, '0, '0, 0);
    cyc();
    idle();
    cyc();

    // reset pulsed while a CPU read is in flight
    drive(1, 0, 8'h10, '0, '0,
          0, 0, '0, '0, '0, 0);
    cyc();
    idle();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_m0_rvalid", 64'(bus.m0_rvalid), 64'd0);
    cyc();
    reset = 1'b0;
    cyc();
    drive(1, 0, 8'h20, '0, '0,
          1, 0, 8'h21, '0, '0, 0);
    #1;
    chk("post_rst_m0_gnt", 64'(bus.m0_gnt), 64'd1);
    cyc();
    idle();
    cyc();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0,
            AW'($urandom_range(0, 15)),
            DW'($urandom),
            SW'($urandom_range(0, 15)),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0,
            AW'($urandom_range(0, 15)),
            DW'($urandom),
            SW'($urandom_range(0, 15)),
            $urandom_range(0, 2) != 0);
      cyc();
    end
    idle();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port synchronous data memory between the CPU load/store port (requester 0) and a host/debug port (requester 1), e.g. a program loader or DMA engine. It sits between the datapath's data-memory interface and the memory array. Grants are issued in the same cycle as the request, with round-robin fairness and a bounded lock for host bursts. A stall output freezes the CPU while it is denied.

## Interface
- ADDR_WIDTH, `ADDR_WIDTH: word address width, shared by both requesters and the memory.
- DATA_WIDTH, 32: data width; strobe width is DATA_WIDTH/8.
- MAX_LOCK, 4: maximum consecutive locked grants to requester 1 while requester 0 waits; must be ≥1.
- Clock and reset: one clock; reset is asynchronous and active-high (ports clk, reset).
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- m0_req, m1_req  in  1  access request.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_addr, m1_addr  in  ADDR_WIDTH  word address.
- m0_wdata, m1_wdata  in  DATA_WIDTH  write data.
- m0_wstrb, m1_wstrb  in  DATA_WIDTH/8  byte enables for writes.
- m1_lock  in  1  requester 1 asks to keep the grant on following cycles.
- m0_gnt, m1_gnt  out  1  request accepted this cycle (combinational).
- m0_rvalid, m1_rvalid  out  1  read data valid (registered).
- m0_rdata, m1_rdata  out  DATA_WIDTH  read data; equals mem_rdata.
- cpu_stall  out  1  m0_req & ~m0_gnt.
- mem_en, mem_we  out  1  memory enable and write enable.
- mem_addr  out  ADDR_WIDTH  winner's address.
- mem_wdata  out  DATA_WIDTH  winner's write data.
- mem_wstrb  out  DATA_WIDTH/8  winner's strobes; 0 when not writing.
- mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after a read enable.

## Operation
- State: last_gnt (1 bit, id of last winner), lock_cnt (clog2(MAX_LOCK+1) bits), rd_owner (2 bits, one-hot owner of the in-flight read).
- Single request: that requester wins.
- Both requesting:
  - If 0 < lock_cnt < MAX_LOCK and m1_lock=1, requester 1 wins.
  - Otherwise the requester ≠ last_gnt wins (round-robin).
- No request: no grant; mem_en=0; mem_* data outputs are 0.
- Winner's we/addr/wdata/wstrb are muxed onto mem_*. mem_en = m0_gnt|m1_gnt; mem_we = winner's we.
- last_gnt updates to the winner on every grant, including uncontended and locked grants.
- lock_cnt next value:
  - if m1_gnt & m1_lock: min(lock_cnt+1, MAX_LOCK);
  - else 0.
- rd_owner next value = {m1_gnt & ~m1_we, m0_gnt & ~m0_we}.
- mN_rvalid = rd_owner[N]. Writes never raise rvalid.
- Exactly one grant or none per cycle; m0_gnt & m1_gnt is never 1.

## Timing
- Reset values: last_gnt=1 (requester 0 wins the first contention), lock_cnt=0, rd_owner=0, so m0_rvalid=m1_rvalid=0.
- Combinational outputs follow their inputs during reset.
- Grant latency: 0 cycles; gnt is valid in the request cycle.
- Write latency: write commits at the clock edge ending the grant cycle.
- Read latency: 1 cycle; rvalid and rdata appear in the cycle after gnt.
- Back-to-back reads: new read data every cycle; a read granted in cycle t and another in t+1 produce rvalid in t+1 and t+2.
- A requester holds req/addr/we stable until gnt. Dropping req before gnt is legal and discards the request.
- Lock bound: a locked requester 1 receives at most MAX_LOCK consecutive grants while m0_req=1; the next cycle goes to requester 0.
- Lock with no m0 request: requester 1 keeps the grant indefinitely; lock_cnt saturates at MAX_LOCK.
- Reset mid-read: rvalid drops immediately (asynchronously), and the pending read never returns.
- cpu_stall is combinational in the same cycle as denial, so the datapath holds PC and pipeline state for that cycle.

## Test plan
- Reset, then both requesters issue reads in cycle 1 -> in cycle 1 m0_gnt=1, m1_gnt=0, cpu_stall=0; in cycle 2 m0_rvalid=1 and m1_rvalid=0 (while reset is held, both rvalids are 0).
- m0 reads addr 0x10 and memory returns 0xDEADBEEF -> mem_en=1, mem_addr=0x10, mem_we=0 in the grant cycle; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF.
- Both request reads, no lock, 4 cycles from reset -> winners m0, m1, m0, m1; cpu_stall=1 in cycles 2 and 4 only.
- MAX_LOCK=4, m1_lock=1, both requesting continuously with last_gnt=0 -> winners m1 ×4, m0 ×1, then m1 again with lock_cnt restarting at 1.
- m1 writes 0xCAFE0000 to addr 0x3 with wstrb 0x3 -> mem_we=1, mem_wstrb=0x3, mem_wdata=0xCAFE0000; m1_rvalid stays 0 the next cycle.
- m0 read granted, then reset pulsed mid-cycle before the next edge -> m0_rvalid falls during reset and stays 0 after release; first contention after reset grants m0.
